// File: rtl/vx_ibuffer_sched_pkg.sv
// Shared sizing helpers and default geometry for the instruction buffer scheduler.
package vx_ibuf_sched_pkg;

   localparam int unsigned DEF_NUM_WARPS = 4;
   localparam int unsigned DEF_DEPTH     = 2;
   localparam int unsigned DEF_DATAW     = 128;

   // A count must hold DEPTH itself, hence DEPTH+1 states.
   localparam int unsigned CNTW = $clog2(DEF_DEPTH + 1);

   typedef logic [CNTW-1:0]                   cnt_t;
   typedef cnt_t [DEF_NUM_WARPS-1:0]          cnt_vec_t;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/vx_ibuffer_sched_if.sv
// Decode-side and issue-side handshake bundle for vx_ibuffer_sched.
interface vx_ibuffer_sched_if
   import vx_ibuf_sched_pkg::*;
#(
   parameter int unsigned NUM_WARPS = DEF_NUM_WARPS,
   parameter int unsigned DATAW     = DEF_DATAW
);
   localparam int unsigned NW_BITS = $clog2(NUM_WARPS);

   logic                 dec_valid;
   logic [NW_BITS-1:0]   dec_wid;
   logic [DATAW-1:0]     dec_data;
   logic                 dec_ready;
   logic [NUM_WARPS-1:0] warp_stall;
   logic [NUM_WARPS-1:0] warp_full;
   logic                 ibuf_valid;
   logic [NW_BITS-1:0]   ibuf_wid;
   logic [DATAW-1:0]     ibuf_data;
   logic                 ibuf_ready;
   logic                 ibuf_valid_n;
   logic [NW_BITS-1:0]   ibuf_wid_n;
   logic [DATAW-1:0]     ibuf_data_n;

   modport master (
      output dec_valid, dec_wid, dec_data, warp_stall, ibuf_ready,
      input  dec_ready, warp_full, ibuf_valid, ibuf_wid, ibuf_data,
      input  ibuf_valid_n, ibuf_wid_n, ibuf_data_n
   );

   modport slave (
      input  dec_valid, dec_wid, dec_data, warp_stall, ibuf_ready,
      output dec_ready, warp_full, ibuf_valid, ibuf_wid, ibuf_data,
      output ibuf_valid_n, ibuf_wid_n, ibuf_data_n
   );

endinterface

// File: rtl/vx_ibuf_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module vx_ibuf_rr_picker #(
   parameter int unsigned NUM_WARPS = 4,
   localparam int unsigned NW_BITS  = $clog2(NUM_WARPS)
) (
   input  logic [NUM_WARPS-1:0] req,
   input  logic [NW_BITS-1:0]   last_grant,
   output logic [NW_BITS-1:0]   sel,
   output logic                 any
);

   always_comb begin
      sel = last_grant;
      any = |req;
      // Walk from farthest to nearest so the nearest requester is written last.
      for (int i = NUM_WARPS; i >= 1; i--) begin
         if (req[last_grant + NW_BITS'(i)]) sel = last_grant + NW_BITS'(i);
      end
   end

endmodule

// File: rtl/vx_ibuffer_sched.sv
// Per-warp instruction FIFOs with a round-robin issue picker and a registered issue stage.
module vx_ibuffer_sched
   import vx_ibuf_sched_pkg::*;
#(
   parameter int unsigned NUM_WARPS = DEF_NUM_WARPS,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned DATAW     = DEF_DATAW
) (
   input logic               clk,
   input logic               reset_n,
   vx_ibuffer_sched_if.slave bus
);
   localparam int unsigned NW_BITS = $clog2(NUM_WARPS);
   localparam int unsigned PTRW    = $clog2(DEPTH);
   localparam int unsigned CNT_W   = cnt_width(DEPTH);

   logic [DATAW-1:0]     ram_q   [NUM_WARPS][DEPTH];
   logic [PTRW-1:0]      head_q  [NUM_WARPS];
   logic [PTRW-1:0]      tail_q  [NUM_WARPS];
   logic [CNT_W-1:0]     count_q [NUM_WARPS];
   logic [NW_BITS-1:0]   last_grant_q;
   logic                 ibuf_valid_q;
   logic [NW_BITS-1:0]   ibuf_wid_q;
   logic [DATAW-1:0]     ibuf_data_q;

   logic [NUM_WARPS-1:0] full, eligible, push_vec, pop_vec;
   logic [NW_BITS-1:0]   sel;
   logic [DATAW-1:0]     sel_data;
   logic                 any, load, push;

   always_comb begin
      full     = '0;
      eligible = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         full[w]     = (count_q[w] == CNT_W'(DEPTH));
         eligible[w] = (count_q[w] != '0) && !bus.warp_stall[w];
      end
   end

   vx_ibuf_rr_picker #(
      .NUM_WARPS (NUM_WARPS)
   ) u_picker (
      .req        (eligible),
      .last_grant (last_grant_q),
      .sel        (sel),
      .any        (any)
   );

   // Readiness uses registered counts only, so a full warp stays blocked while being popped.
   assign push     = bus.dec_valid && !full[bus.dec_wid];
   assign load     = any && (!ibuf_valid_q || bus.ibuf_ready);
   assign sel_data = ram_q[sel][head_q[sel]];

   always_comb begin
      push_vec = '0;
      pop_vec  = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         push_vec[w] = push && (bus.dec_wid == NW_BITS'(w));
         pop_vec[w]  = load && (sel == NW_BITS'(w));
      end
   end

   always_ff @(posedge clk) begin
      if (push) ram_q[bus.dec_wid][tail_q[bus.dec_wid]] <= bus.dec_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            head_q[w]  <= '0;
            tail_q[w]  <= '0;
            count_q[w] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (push_vec[w]) tail_q[w] <= tail_q[w] + PTRW'(1);
            if (pop_vec[w])  head_q[w] <= head_q[w] + PTRW'(1);
            count_q[w] <= count_q[w] + CNT_W'(push_vec[w]) - CNT_W'(pop_vec[w]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= NW_BITS'(NUM_WARPS - 1);
         ibuf_valid_q <= 1'b0;
         ibuf_wid_q   <= '0;
         ibuf_data_q  <= '0;
      end else if (load) begin
         last_grant_q <= sel;
         ibuf_valid_q <= 1'b1;
         ibuf_wid_q   <= sel;
         ibuf_data_q  <= sel_data;
      end else if (ibuf_valid_q && bus.ibuf_ready) begin
         ibuf_valid_q <= 1'b0;
      end
   end

   assign bus.dec_ready    = !full[bus.dec_wid];
   assign bus.warp_full    = full;
   assign bus.ibuf_valid   = ibuf_valid_q;
   assign bus.ibuf_wid     = ibuf_wid_q;
   assign bus.ibuf_data    = ibuf_data_q;
   assign bus.ibuf_valid_n = any;
   assign bus.ibuf_wid_n   = sel;
   assign bus.ibuf_data_n  = sel_data;

endmodule

// File: tb/tb_vx_ibuffer_sched.sv
// Directed vector table, hand sequences and a queue-based random model for vx_ibuffer_sched.
module tb_vx_ibuffer_sched;
   import vx_ibuf_sched_pkg::*;

   localparam int NW = 4;
   localparam int DEPTH = 2;
   localparam int DW = 128;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   vx_ibuffer_sched_if #(.NUM_WARPS(NW), .DATAW(DW)) bus ();

   vx_ibuffer_sched #(
      .NUM_WARPS (NW),
      .DEPTH     (DEPTH),
      .DATAW     (DW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic [1:0] wid, input logic [DW-1:0] data,
                        input logic [3:0] stall, input logic rdy);
      bus.dec_valid  = dv;
      bus.dec_wid    = wid;
      bus.dec_data   = data;
      bus.warp_stall = stall;
      bus.ibuf_ready = rdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      drive(1'b0, 2'd0, '0, 4'h0, 1'b0);
      #2 reset_n = 1'b1;
   endtask

   typedef struct {
      logic       dv;
      logic [1:0] wid;
      logic [7:0] data;
      logic [3:0] stall;
      logic       rdy;
      logic       e_v;
      logic [1:0] e_wid;
      logic [7:0] e_data;
      logic       e_vn;
      logic [1:0] e_wn;
      logic [7:0] e_dn;
      logic       e_drdy;
      logic [3:0] e_full;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic dv, input logic [1:0] wid, input logic [7:0] data,
                               input logic [3:0] stall, input logic rdy, input logic e_v,
                               input logic [1:0] e_wid, input logic [7:0] e_data,
                               input logic e_vn, input logic [1:0] e_wn, input logic [7:0] e_dn,
                               input logic e_drdy, input logic [3:0] e_full);
      vec_t v;
      v.dv = dv; v.wid = wid; v.data = data; v.stall = stall; v.rdy = rdy;
      v.e_v = e_v; v.e_wid = e_wid; v.e_data = e_data;
      v.e_vn = e_vn; v.e_wn = e_wn; v.e_dn = e_dn;
      v.e_drdy = e_drdy; v.e_full = e_full;
      return v;
   endfunction

   // Reference model: plain queues per warp plus the issue register contents.
   logic [DW-1:0] mq [NW][$];
   int            m_last;
   bit            m_valid;
   int            m_wid;
   logic [DW-1:0] m_data;

   initial begin
      logic [DW-1:0] rdata;
      logic [1:0]    rwid;
      logic [3:0]    rstall, efull;
      logic          rdv, rrdy, edrdy, evn, eload;
      int            esel;

      tbl[0]  = mk(1'b1, 2'd2, 8'hA5, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[1]  = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'hA5, 1'b1, 4'h0);
      tbl[2]  = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[3]  = mk(1'b1, 2'd1, 8'h11, 4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[4]  = mk(1'b1, 2'd1, 8'h12, 4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[5]  = mk(1'b1, 2'd1, 8'h13, 4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'h2);
      tbl[6]  = mk(1'b1, 2'd3, 8'h31, 4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h2);
      tbl[7]  = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h31, 1'b1, 4'h2);
      tbl[8]  = mk(1'b1, 2'd1, 8'h13, 4'h0, 1'b0, 1'b1, 2'd3, 8'h31, 1'b1, 2'd1, 8'h11, 1'b0, 4'h2);
      tbl[9]  = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b1, 2'd3, 8'h31, 1'b1, 2'd1, 8'h11, 1'b1, 4'h2);
      tbl[10] = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd3, 8'h31, 1'b1, 2'd1, 8'h11, 1'b1, 4'h2);
      tbl[11] = mk(1'b1, 2'd1, 8'h13, 4'h0, 1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd1, 8'h12, 1'b1, 4'h0);
      tbl[12] = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd1, 8'h12, 1'b1, 2'd1, 8'h13, 1'b1, 4'h0);
      tbl[13] = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd1, 8'h13, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[14] = mk(1'b1, 2'd0, 8'h40, 4'h1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[15] = mk(1'b1, 2'd1, 8'h41, 4'h1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[16] = mk(1'b0, 2'd0, 8'h00, 4'h1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h41, 1'b1, 4'h0);
      tbl[17] = mk(1'b0, 2'd0, 8'h00, 4'h1, 1'b1, 1'b1, 2'd1, 8'h41, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
      tbl[18] = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h40, 1'b1, 4'h0);
      tbl[19] = mk(1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd0, 8'h40, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0);

      // Reset state.
      drive(1'b0, 2'd0, '0, 4'h0, 1'b0);
      #12 reset_n = 1'b1;
      #1;
      chk("reset valid", DW'(bus.ibuf_valid), '0);
      chk("reset wid", DW'(bus.ibuf_wid), '0);
      chk("reset data", bus.ibuf_data, '0);
      chk("reset full", DW'(bus.warp_full), '0);
      chk("reset dec_ready", DW'(bus.dec_ready), DW'(1));

      // Directed vectors, one row per cycle.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(tbl[i].dv, tbl[i].wid, DW'(tbl[i].data), tbl[i].stall, tbl[i].rdy);
         #1;
         chk($sformatf("row%0d valid", i), DW'(bus.ibuf_valid), DW'(tbl[i].e_v));
         if (tbl[i].e_v) begin
            chk($sformatf("row%0d wid", i), DW'(bus.ibuf_wid), DW'(tbl[i].e_wid));
            chk($sformatf("row%0d data", i), bus.ibuf_data, DW'(tbl[i].e_data));
         end
         chk($sformatf("row%0d valid_n", i), DW'(bus.ibuf_valid_n), DW'(tbl[i].e_vn));
         if (tbl[i].e_vn) begin
            chk($sformatf("row%0d wid_n", i), DW'(bus.ibuf_wid_n), DW'(tbl[i].e_wn));
            chk($sformatf("row%0d data_n", i), bus.ibuf_data_n, DW'(tbl[i].e_dn));
         end
         chk($sformatf("row%0d dec_ready", i), DW'(bus.dec_ready), DW'(tbl[i].e_drdy));
         chk($sformatf("row%0d warp_full", i), DW'(bus.warp_full), DW'(tbl[i].e_full));
      end

      // Round-robin fairness: two entries per warp, then drain with no bubbles.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1'b1, 2'(i % NW), DW'(8'h50 + i), 4'hF, 1'b1);
      end
      @(negedge clk);
      drive(1'b0, 2'd0, '0, 4'h0, 1'b1);
      #1 chk("rr all full", DW'(bus.warp_full), DW'(4'hF));
      chk("rr first valid", DW'(bus.ibuf_valid), '0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rr%0d valid", k), DW'(bus.ibuf_valid), DW'(1));
         chk($sformatf("rr%0d wid", k), DW'(bus.ibuf_wid), DW'(k % NW));
         chk($sformatf("rr%0d data", k), bus.ibuf_data, DW'(8'h50 + k));
      end
      @(negedge clk);
      #1 chk("rr drained", DW'(bus.ibuf_valid), '0);

      // Reset mid-stream with three warps queued and the output register loaded.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 2'(i), DW'(8'h70 + i), 4'hF, 1'b0);
      end
      @(negedge clk);
      drive(1'b0, 2'd0, '0, 4'h0, 1'b0);
      @(negedge clk);
      #1 chk("mid valid before reset", DW'(bus.ibuf_valid), DW'(1));
      #1 reset_n = 1'b0;
      #1;
      chk("mid async valid", DW'(bus.ibuf_valid), '0);
      chk("mid async valid_n", DW'(bus.ibuf_valid_n), '0);
      chk("mid async full", DW'(bus.warp_full), '0);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive(1'b0, 2'd0, '0, 4'h0, 1'b1);
         #1;
         chk($sformatf("mid%0d valid", k), DW'(bus.ibuf_valid), '0);
         chk($sformatf("mid%0d valid_n", k), DW'(bus.ibuf_valid_n), '0);
      end

      // Random traffic against the queue model.
      do_reset();
      for (int w = 0; w < NW; w++) mq[w].delete();
      m_last = NW - 1;
      m_valid = 1'b0;
      m_wid = 0;
      m_data = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rdv    = ($urandom_range(0, 9) < 7);
         rwid   = 2'($urandom_range(0, NW - 1));
         rdata  = {$urandom, $urandom, $urandom, $urandom};
         rrdy   = ($urandom_range(0, 3) != 0);
         for (int w = 0; w < NW; w++) rstall[w] = ($urandom_range(0, 4) == 0);
         drive(rdv, rwid, rdata, rstall, rrdy);
         #1;
         edrdy = (mq[rwid].size() != DEPTH);
         for (int w = 0; w < NW; w++) efull[w] = (mq[w].size() == DEPTH);
         evn  = 1'b0;
         esel = 0;
         for (int k = 1; k <= NW; k++) begin
            int w;
            w = (m_last + k) % NW;
            if (!evn && mq[w].size() != 0 && !rstall[w]) begin
               evn  = 1'b1;
               esel = w;
            end
         end
         chk("rand dec_ready", DW'(bus.dec_ready), DW'(edrdy));
         chk("rand warp_full", DW'(bus.warp_full), DW'(efull));
         chk("rand valid_n", DW'(bus.ibuf_valid_n), DW'(evn));
         if (evn) begin
            chk("rand wid_n", DW'(bus.ibuf_wid_n), DW'(esel));
            chk("rand data_n", bus.ibuf_data_n, mq[esel][0]);
         end
         chk("rand valid", DW'(bus.ibuf_valid), DW'(m_valid));
         if (m_valid) begin
            chk("rand wid", DW'(bus.ibuf_wid), DW'(m_wid));
            chk("rand data", bus.ibuf_data, m_data);
         end
         eload = evn && (!m_valid || rrdy);
         if (eload) begin
            m_valid = 1'b1;
            m_wid   = esel;
            m_data  = mq[esel].pop_front();
            m_last  = esel;
         end else if (m_valid && rrdy) begin
            m_valid = 1'b0;
         end
         if (rdv && edrdy) mq[rwid].push_back(rdata);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
